ram_dump_reader: RTL and testbench

- Read-side counterpart to the RAM initializer: once the SLC-3 is idle, sweeps a contiguous window of the on-chip RAM and streams the words out over a valid/ready interface, for debug dump or verification.
- Takes the RAM port through a select line, the same way the initializer's we_select does.
- Absorbs the synchronous-RAM read latency with a small skid FIFO.
- Keeps a running 16-bit checksum of the words delivered.

---
 rtl/ram_dump_reader_if.sv | 24 ++
 rtl/ram_dump_reader.sv | 138 +++++++++++++
 tb/tb_ram_dump_reader.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dump_reader_if.sv
// RAM read port plus the outgoing valid/ready word stream of the RAM dump reader.
// The master side is the dump reader; the slave side is the RAM mux and the consumer.
interface ram_dump_reader_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
);
   logic              rd_select;
   logic [ADDR_W-1:0] ADDR;
   logic              rden;
   logic [DATA_W-1:0] q;
   logic [DATA_W-1:0] Data_out;
   logic              Data_valid;
   logic              Data_ready;

   modport master (
      output rd_select, ADDR, rden, Data_out, Data_valid,
      input  q, Data_ready
   );

   modport slave (
      input  rd_select, ADDR, rden, Data_out, Data_valid,
      output q, Data_ready
   );
endinterface

// File: rtl/ram_dump_reader.sv
// Sweeps a window of on-chip RAM once the CPU is idle and streams the words out,
// absorbing the synchronous read latency in a small skid FIFO and summing what it delivers.
module ram_dump_reader #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [ADDR_W-1:0] Start_ADDR,
   input  logic [ADDR_W:0]   Count,
   ram_dump_reader_if.master bus,
   output logic              Busy,
   output logic              Done,
   output logic [DATA_W-1:0] Checksum
);

   localparam int DEPTH = RD_LATENCY + 1;
   localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_hold_q;
   logic [ADDR_W:0]     remaining_q;
   logic [RD_LATENCY-1:0] pipe_q;
   logic [DATA_W-1:0]   fifo_mem [DEPTH];
   logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]    fifo_cnt_q;
   logic [CNT_W-1:0]    inflight;
   logic [CNT_W:0]      outstanding;
   logic [DATA_W-1:0]   checksum_q;
   logic                done_q;
   logic                issue, push, pop, data_valid, rd_select;
   logic [DATA_W-1:0]   data_out;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign data_valid = (fifo_cnt_q != '0);
   assign data_out   = data_valid ? fifo_mem[rd_ptr_q] : '0;
   assign pop        = data_valid && bus.Data_ready;
   assign push       = pipe_q[RD_LATENCY-1];

   // The word leaving this cycle frees its slot, so it is credited before the
   // issue decision; that is what sustains one word per cycle with Data_ready high.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_W'(pipe_q[i]);
      outstanding = {1'b0, fifo_cnt_q} + {1'b0, inflight} - {{CNT_W{1'b0}}, pop};
   end

   assign issue = (state_q == RUN) && (remaining_q != '0) &&
                  (outstanding < (CNT_W + 1)'(DEPTH));

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      rd_select = 1'b0;
      Busy      = 1'b0;
      case (state_q)
         IDLE: if (Start) state_d = (Count == '0) ? DONE : RUN;
         RUN: begin
            rd_select = 1'b1;
            Busy      = 1'b1;
            if (issue && remaining_q == (ADDR_W + 1)'(1)) state_d = DRAIN;
         end
         DRAIN: begin
            rd_select = (pipe_q != '0);
            Busy      = 1'b1;
            if (pipe_q == '0 && fifo_cnt_q == '0) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         addr_q      <= '0;
         addr_hold_q <= '0;
         remaining_q <= '0;
         pipe_q      <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
         checksum_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         done_q <= (state_q == DONE);
         pipe_q <= RD_LATENCY'({pipe_q, issue});

         if (state_q == IDLE && Start) begin
            addr_q      <= Start_ADDR;
            remaining_q <= Count;
            checksum_q  <= '0;
         end else if (issue) begin
            addr_q      <= addr_q + 1'b1;
            addr_hold_q <= addr_q;
            remaining_q <= remaining_q - 1'b1;
         end

         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop) begin
            rd_ptr_q   <= ptr_inc(rd_ptr_q);
            checksum_q <= checksum_q + data_out;
         end
         case ({push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

   // NOTE: FIFO storage is not reset; an empty FIFO masks Data_out to zero instead.
   always_ff @(posedge Clk) begin
      if (push) fifo_mem[wr_ptr_q] <= bus.q;
   end

   assign bus.rd_select  = rd_select;
   assign bus.rden       = issue;
   assign bus.ADDR       = issue ? addr_q : addr_hold_q;
   assign bus.Data_out   = data_out;
   assign bus.Data_valid = data_valid;
   assign Done           = done_q;
   assign Checksum       = checksum_q;

endmodule

// File: tb/tb_ram_dump_reader.sv
// Directed bench for ram_dump_reader: a latency-1 and a latency-2 instance against
// behavioural RAMs holding mem[a] = a + 16'h3000, checked through address/data scoreboards.
module tb_ram_dump_reader;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 16;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // ---------------- DUT A: RD_LATENCY = 1 ----------------
   logic              start_a;
   logic [ADDR_W-1:0] start_addr_a;
   logic [ADDR_W:0]   count_a;
   logic              busy_a, done_a;
   logic [DATA_W-1:0] checksum_a;
   ram_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();

   ram_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(1)) dut_a (
      .Clk(Clk), .Reset(Reset), .Start(start_a), .Start_ADDR(start_addr_a),
      .Count(count_a), .bus(bus_a.master), .Busy(busy_a), .Done(done_a),
      .Checksum(checksum_a)
   );

   // ---------------- DUT B: RD_LATENCY = 2 ----------------
   logic              start_b;
   logic [ADDR_W-1:0] start_addr_b;
   logic [ADDR_W:0]   count_b;
   logic              busy_b, done_b;
   logic [DATA_W-1:0] checksum_b;
   ram_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

   ram_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(2)) dut_b (
      .Clk(Clk), .Reset(Reset), .Start(start_b), .Start_ADDR(start_addr_b),
      .Count(count_b), .bus(bus_b.master), .Busy(busy_b), .Done(done_b),
      .Checksum(checksum_b)
   );

   function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
      return DATA_W'(a) + 16'h3000;
   endfunction

   // Behavioural RAMs
   logic [DATA_W-1:0] q_b1;
   always @(posedge Clk) if (bus_a.rden) bus_a.q <= ram_word(bus_a.ADDR);
   always @(posedge Clk) begin
      if (bus_b.rden) q_b1 <= ram_word(bus_b.ADDR);
      bus_b.q <= q_b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard A ----------------
   logic [ADDR_W-1:0] exp_addr_a[$];
   logic [DATA_W-1:0] exp_data_a[$];
   logic [DATA_W-1:0] model_sum_a;
   int issued_a, delivered_a, max_out_a, first_rden_a, first_valid_a, xfer_first_a, xfer_last_a;
   logic              prev_stall_a;
   logic [DATA_W-1:0] prev_data_a;

   always @(negedge Clk) begin
      if (Reset) begin
         prev_stall_a = 1'b0;
      end else begin
         if (bus_a.rden) begin
            issued_a++;
            if (first_rden_a < 0) first_rden_a = cyc;
            check("a_rden_owns_bus", bus_a.rd_select, 1'b1);
            check("a_rd_expected", exp_addr_a.size() > 0, 1'b1);
            if (exp_addr_a.size() > 0) check("a_rd_addr", bus_a.ADDR, exp_addr_a.pop_front());
         end
         if (prev_stall_a) begin
            check("a_stall_valid", bus_a.Data_valid, 1'b1);
            check("a_stall_data", bus_a.Data_out, prev_data_a);
         end
         if (bus_a.Data_valid && first_valid_a < 0) first_valid_a = cyc;
         if (bus_a.Data_valid && bus_a.Data_ready) begin
            delivered_a++;
            if (xfer_first_a < 0) xfer_first_a = cyc;
            xfer_last_a = cyc;
            check("a_word_expected", exp_data_a.size() > 0, 1'b1);
            if (exp_data_a.size() > 0) begin
               logic [DATA_W-1:0] e;
               e = exp_data_a.pop_front();
               check("a_data", bus_a.Data_out, e);
               model_sum_a = model_sum_a + e;
            end
         end
         if (issued_a - delivered_a > max_out_a) max_out_a = issued_a - delivered_a;
         prev_stall_a = bus_a.Data_valid && !bus_a.Data_ready;
         prev_data_a  = bus_a.Data_out;
      end
   end

   // ---------------- scoreboard B ----------------
   logic [ADDR_W-1:0] exp_addr_b[$];
   logic [DATA_W-1:0] exp_data_b[$];
   logic [DATA_W-1:0] model_sum_b;
   int issued_b, delivered_b, first_rden_b, first_valid_b;

   always @(negedge Clk) begin
      if (!Reset) begin
         if (bus_b.rden) begin
            issued_b++;
            if (first_rden_b < 0) first_rden_b = cyc;
            check("b_rd_expected", exp_addr_b.size() > 0, 1'b1);
            if (exp_addr_b.size() > 0) check("b_rd_addr", bus_b.ADDR, exp_addr_b.pop_front());
         end
         if (bus_b.Data_valid && first_valid_b < 0) first_valid_b = cyc;
         if (bus_b.Data_valid && bus_b.Data_ready) begin
            delivered_b++;
            check("b_word_expected", exp_data_b.size() > 0, 1'b1);
            if (exp_data_b.size() > 0) begin
               logic [DATA_W-1:0] e;
               e = exp_data_b.pop_front();
               check("b_data", bus_b.Data_out, e);
               model_sum_b = model_sum_b + e;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   int start_cyc;

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic start_dump_a(input logic [ADDR_W-1:0] a, input int n);
      for (int i = 0; i < n; i++) begin
         exp_addr_a.push_back(a + ADDR_W'(i));
         exp_data_a.push_back(ram_word(a + ADDR_W'(i)));
      end
      issued_a = 0; delivered_a = 0; max_out_a = 0; model_sum_a = '0;
      first_rden_a = -1; first_valid_a = -1; xfer_first_a = -1; xfer_last_a = -1;
      start_addr_a = a;
      count_a      = (ADDR_W + 1)'(n);
      start_a      = 1'b1;
      start_cyc    = cyc;
      tick(1);
      start_a = 1'b0;
   endtask

   // Waits (bounded) for Done, optionally toggling Data_ready 1,0,0,1; checks the pulse is one cycle.
   task automatic wait_done_a(input string tag, input int budget, input bit toggle,
                              output int done_cyc);
      done_cyc = -1;
      for (int n = 0; n < budget; n++) begin
         if (toggle) bus_a.Data_ready = (n % 4 == 0) || (n % 4 == 3);
         @(negedge Clk);
         if (done_a) begin
            done_cyc = cyc;
            break;
         end
         tick(1);
      end
      check({tag, "_done"}, done_a, 1'b1);
      tick(1);
      check({tag, "_done_pulse"}, done_a, 1'b0);
      check({tag, "_busy_after"}, busy_a, 1'b0);
      bus_a.Data_ready = 1'b1;
   endtask

   task automatic check_idle_a(input string tag);
      check({tag, "_busy"},      busy_a,           1'b0);
      check({tag, "_done"},      done_a,           1'b0);
      check({tag, "_rd_select"}, bus_a.rd_select,  1'b0);
      check({tag, "_rden"},      bus_a.rden,       1'b0);
      check({tag, "_valid"},     bus_a.Data_valid, 1'b0);
      check({tag, "_addr"},      bus_a.ADDR,       '0);
      check({tag, "_data_out"},  bus_a.Data_out,   '0);
      check({tag, "_checksum"},  checksum_a,       '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int done_cyc;
      Reset = 1'b1;
      start_a = 1'b0; start_addr_a = '0; count_a = '0; bus_a.Data_ready = 1'b0;
      start_b = 1'b0; start_addr_b = '0; count_b = '0; bus_b.Data_ready = 1'b0;
      issued_a = 0; delivered_a = 0; max_out_a = 0; model_sum_a = '0;
      first_rden_a = -1; first_valid_a = -1; xfer_first_a = -1; xfer_last_a = -1;
      prev_stall_a = 1'b0;
      issued_b = 0; delivered_b = 0; model_sum_b = '0; first_rden_b = -1; first_valid_b = -1;
      tick(3);
      check_idle_a("reset");
      check("reset_b_busy",  busy_b,           1'b0);
      check("reset_b_valid", bus_b.Data_valid, 1'b0);
      Reset = 1'b0;
      bus_a.Data_ready = 1'b1;
      bus_b.Data_ready = 1'b1;
      tick(2);

      // 1: four words from address 0 at full rate
      start_dump_a(10'h000, 4);
      wait_done_a("t1", 60, 1'b0, done_cyc);
      check("t1_start_to_rden",  first_rden_a - start_cyc,    1);
      check("t1_rden_to_valid",  first_valid_a - first_rden_a, 2);
      check("t1_back_to_back",   xfer_last_a - xfer_first_a,  3);
      check("t1_delivered",      delivered_a,                 4);
      check("t1_checksum",       checksum_a,                  16'hC006);
      check("t1_sb_empty",       exp_data_a.size(),           0);

      // 2: window wrapping past the top of the address space
      start_dump_a(10'h3FE, 4);
      wait_done_a("t2", 60, 1'b0, done_cyc);
      check("t2_delivered", delivered_a, 4);
      check("t2_checksum",  checksum_a,  16'hC7FE);
      check("t2_addr_used", exp_addr_a.size(), 0);

      // 3: empty dump
      start_dump_a(10'h055, 0);
      wait_done_a("t3", 20, 1'b0, done_cyc);
      check("t3_done_latency", done_cyc - start_cyc, 2);
      check("t3_no_rden",      issued_a,      0);
      check("t3_no_valid",     first_valid_a, -1);
      check("t3_checksum",     checksum_a,    '0);

      // 4: consumer back-pressure
      start_dump_a(10'h020, 8);
      wait_done_a("t4", 200, 1'b1, done_cyc);
      check("t4_delivered",       delivered_a,      8);
      check("t4_outstanding_max", max_out_a <= 2,   1'b1);
      check("t4_checksum",        checksum_a,       model_sum_a);
      check("t4_sb_empty",        exp_data_a.size(), 0);

      // 5: reset in the middle of a dump
      start_dump_a(10'h100, 10);
      for (int n = 0; n < 50 && delivered_a < 3; n++) tick(1);
      check("t5_reached_3", delivered_a >= 3, 1'b1);
      Reset = 1'b1;
      bus_a.Data_ready = 1'b0;
      tick(1);
      Reset = 1'b0;
      exp_addr_a.delete();
      exp_data_a.delete();
      check_idle_a("t5_rst");
      issued_a = 0; first_valid_a = -1;
      bus_a.Data_ready = 1'b1;
      tick(10);
      check("t5_no_rden_after",  issued_a,      0);
      check("t5_no_valid_after", first_valid_a, -1);
      start_dump_a(10'h005, 3);
      wait_done_a("t5_restart", 60, 1'b0, done_cyc);
      check("t5_restart_count", delivered_a, 3);
      check("t5_restart_sum",   checksum_a,  model_sum_a);

      // 6: Start during RUN must be ignored
      start_dump_a(10'h040, 6);
      tick(2);
      start_addr_a = 10'h200;
      count_a      = 11'd2;
      start_a      = 1'b1;
      tick(1);
      start_a = 1'b0;
      wait_done_a("t6", 80, 1'b0, done_cyc);
      tick(4);
      check("t6_issued",    issued_a,          6);
      check("t6_delivered", delivered_a,       6);
      check("t6_checksum",  checksum_a,        model_sum_a);
      check("t6_sb_empty",  exp_data_a.size(), 0);
      check("t6_idle",      busy_a,            1'b0);

      // 7: latency-2 instance
      for (int i = 0; i < 5; i++) begin
         exp_addr_b.push_back(10'h010 + ADDR_W'(i));
         exp_data_b.push_back(ram_word(10'h010 + ADDR_W'(i)));
      end
      start_addr_b = 10'h010;
      count_b      = 11'd5;
      start_b      = 1'b1;
      tick(1);
      start_b = 1'b0;
      done_cyc = -1;
      for (int n = 0; n < 60; n++) begin
         @(negedge Clk);
         if (done_b) begin
            done_cyc = cyc;
            break;
         end
         tick(1);
      end
      check("t7_done",           done_b,                       1'b1);
      check("t7_rden_to_valid",  first_valid_b - first_rden_b, 3);
      check("t7_delivered",      delivered_b,                  5);
      check("t7_checksum",       checksum_b,                   model_sum_b);
      tick(1);
      check("t7_done_pulse",     done_b,                       1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
